// File: rtl/fir_out_decim.sv
// fir_out_decim
// -------------
// Output stage for a FIR filter: discards the first WARMUP valid samples after
// reset (filter settling), keeps one of every DECIM samples, rounds the kept
// sample by SHIFT bits (round half toward +inf), limits it to 16 bits and
// buffers it in a 4-entry FIFO with ready/valid handshake on the consumer side.
//
// Parameters
//   WARMUP : leading valid samples discarded after reset (0 = none)
//   DECIM  : decimation ratio, 1..16
//   SHIFT  : rounding right-shift, 1..20
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   in_valid  in   1   din carries a sample this cycle
//   din       in  30   signed filter sample
//   out_data  out 16   signed sample at FIFO head
//   out_valid out  1   FIFO non-empty
//   out_ready in   1   consumer takes out_data when out_valid is high
//   fill      out  3   FIFO occupancy 0..4
//   ovf_flag  out  1   sticky: sample dropped on full FIFO
//   sat_flag  out  1   sticky: a sample was clipped
//
// Build option
//   FIR_OUT_DECIM_SAT_EN : when defined, the rounded value is clipped to
//   [-32768, 32767] and sat_flag reports clipping; otherwise the low 16 bits
//   are taken (two's-complement wrap) and sat_flag stays 0.
//
// Latency: a sample kept at edge k is in stage 1 after k, stage 2 after k+1
// and in the FIFO (out_valid high if it was empty) after k+2.

module fir_out_decim #(
    parameter int WARMUP = 13,
    parameter int DECIM  = 2,
    parameter int SHIFT  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [29:0] din,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  fill,
    output logic        ovf_flag,
    output logic        sat_flag
);

    typedef enum logic [0:0] {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam bit               WARMUP_ZERO = (WARMUP == 0);
    localparam logic [15:0]      WARM_LAST   = WARMUP_ZERO ? 16'd0 : 16'(WARMUP - 1);
    localparam logic [3:0]       PHASE_LAST  = 4'(DECIM - 1);
    localparam logic signed [30:0] RND_CONST = 31'sd1 <<< (SHIFT - 1);

    // Limits a 31-bit rounded value to 16 bits; bit 16 of the result flags clipping.
    function automatic logic [16:0] limit16(input logic signed [30:0] v);
        logic [16:0] res;
`ifdef FIR_OUT_DECIM_SAT_EN
        if (v > 31'sd32767) begin
            res = {1'b1, 16'h7FFF};
        end else if (v < -31'sd32768) begin
            res = {1'b1, 16'h8000};
        end else begin
            res = {1'b0, v[15:0]};
        end
`else
        res = {1'b0, v[15:0]};
`endif
        return res;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [15:0]        warm_cnt_r;
    logic [3:0]         phase_r;
    logic               run_s;
    logic               keep_s;
    logic signed [30:0] din_ext_s;
    logic signed [30:0] sum_s;
    logic signed [30:0] r_s;

    logic               s1_valid_r;
    logic signed [30:0] s1_data_r;
    logic               s2_valid_r;
    logic [15:0]        s2_data_r;
    logic               s2_clip_r;
    logic [16:0]        lim_s;

    logic [15:0]        mem_r [4];
    logic [1:0]         wr_ptr_r;
    logic [1:0]         rd_ptr_r;
    logic [2:0]         fill_r;
    logic               ovf_r;
    logic               sat_r;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               accept_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_WARM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: leave WARM after the last discarded sample (or at once if WARMUP is 0).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WARM: begin
                if (WARMUP_ZERO) begin
                    state_next_s = ST_RUN;
                end else if (in_valid && (warm_cnt_r == WARM_LAST)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_WARM;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_WARM;
        endcase
    end

    // Keep decision and rounding of the incoming sample.
    // With WARMUP=0 the WARM cycle right after reset already behaves as RUN.
    always_comb begin
        run_s     = (state_r == ST_RUN) || WARMUP_ZERO;
        keep_s    = in_valid && run_s && (phase_r == 4'd0);
        din_ext_s = {din[29], din};
        sum_s     = din_ext_s + RND_CONST;
        r_s       = sum_s >>> SHIFT;
        lim_s     = limit16(s1_data_r);
    end

    // Warm-up counter: counts discarded samples, saturates at the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt_r <= 16'd0;
        end else if ((state_r == ST_WARM) && in_valid && !WARMUP_ZERO && (warm_cnt_r != WARM_LAST)) begin
            warm_cnt_r <= warm_cnt_r + 16'd1;
        end else begin
            warm_cnt_r <= warm_cnt_r;
        end
    end

    // Decimation phase: advances on every valid sample while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 4'd0;
        end else if (in_valid && run_s) begin
            phase_r <= (phase_r == PHASE_LAST) ? 4'd0 : phase_r + 4'd1;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Stage 1: rounded value of the kept sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 31'sd0;
        end else begin
            s1_valid_r <= keep_s;
            if (keep_s) begin
                s1_data_r <= r_s;
            end
        end
    end

    // Stage 2: 16-bit limited value plus clip indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= 16'd0;
            s2_clip_r  <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= lim_s[15:0];
                s2_clip_r <= lim_s[16];
            end else begin
                s2_clip_r <= 1'b0;
            end
        end
    end

    // FIFO handshake terms; a pop frees the slot the push needs when full.
    always_comb begin
        push_s   = s2_valid_r;
        pop_s    = (fill_r != 3'd0) && out_ready;
        full_s   = (fill_r == 3'd4);
        accept_s = push_s && (!full_s || pop_s);
    end

    // FIFO storage, pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 16'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            fill_r   <= 3'd0;
            ovf_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= s2_data_r;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({accept_s, pop_s})
                2'b10:   fill_r <= fill_r + 3'd1;
                2'b01:   fill_r <= fill_r - 3'd1;
                default: fill_r <= fill_r;
            endcase
            if (push_s && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Sticky clip flag, set as the clipped sample reaches the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (s2_valid_r && s2_clip_r) begin
            sat_r <= 1'b1;
        end else begin
            sat_r <= sat_r;
        end
    end

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = (fill_r != 3'd0);
    assign fill      = fill_r;
    assign ovf_flag  = ovf_r;
    assign sat_flag  = sat_r;

endmodule

// File: tb/tb_fir_out_decim.sv
// Self-checking bench for fir_out_decim.
// DUT a: default parameters (WARMUP=13, DECIM=2, SHIFT=12).
// DUT b: WARMUP=0, DECIM=1, SHIFT=12.
module tb_fir_out_decim;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_out_ready, a_out_valid, a_ovf, a_sat;
    logic [29:0] a_din;
    logic [15:0] a_out_data;
    logic [2:0]  a_fill;

    logic        b_in_valid, b_out_ready, b_out_valid, b_ovf, b_sat;
    logic [29:0] b_din;
    logic [15:0] b_out_data;
    logic [2:0]  b_fill;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_out_decim u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .din(a_din),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .fill(a_fill), .ovf_flag(a_ovf), .sat_flag(a_sat)
    );

    fir_out_decim #(.WARMUP(0), .DECIM(1), .SHIFT(12)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .din(b_din),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .fill(b_fill), .ovf_flag(b_ovf), .sat_flag(b_sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_din = 30'd0; b_din = 30'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        do_reset();
        total++; if (a_fill !== 3'd0)      begin bad++; $display("FAIL rst_a_fill: got %0d want 0", a_fill); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_a_valid: got %b want 0", a_out_valid); end
        total++; if (a_out_data !== 16'd0) begin bad++; $display("FAIL rst_a_data: got %0d want 0", a_out_data); end
        total++; if (a_ovf !== 1'b0)       begin bad++; $display("FAIL rst_a_ovf: got %b want 0", a_ovf); end
        total++; if (a_sat !== 1'b0)       begin bad++; $display("FAIL rst_a_sat: got %b want 0", a_sat); end
        total++; if (b_fill !== 3'd0)      begin bad++; $display("FAIL rst_b_fill: got %0d want 0", b_fill); end
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_valid: got %b want 0", b_out_valid); end
        total++; if (b_out_data !== 16'd0) begin bad++; $display("FAIL rst_b_data: got %0d want 0", b_out_data); end
        total++; if (b_ovf !== 1'b0)       begin bad++; $display("FAIL rst_b_ovf: got %b want 0", b_ovf); end
        total++; if (b_sat !== 1'b0)       begin bad++; $display("FAIL rst_b_sat: got %b want 0", b_sat); end
    endtask

    // 13 samples discarded, sample 14 kept (visible after edge 16), sample 16 kept (after edge 18).
    task automatic test_warmup();
        logic exp_v;
        do_reset();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_din       = 30'd4096;
        for (int e = 1; e <= 18; e++) begin
            step();
            exp_v = (e == 16) || (e == 18);
            total++;
            if (a_out_valid !== exp_v) begin
                bad++; $display("FAIL warmup_valid edge %0d: got %b want %b", e, a_out_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (a_out_data !== 16'd1) begin
                    bad++; $display("FAIL warmup_data edge %0d: got %0d want 1", e, a_out_data);
                end
            end
        end
        a_in_valid = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_rounding();
        logic [29:0] vin [4];
        logic [15:0] vexp [4];
        vin[0] = 30'sd2048;  vexp[0] = 16'd1;
        vin[1] = 30'sd2047;  vexp[1] = 16'd0;
        vin[2] = -30'sd2048; vexp[2] = 16'd0;
        vin[3] = -30'sd2049; vexp[3] = 16'hFFFF;
        do_reset();
        b_out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            b_in_valid = (j < 4);
            b_din      = (j < 4) ? vin[j] : 30'd0;
            step();
            if (j >= 2) begin
                total++;
                if (b_out_valid !== 1'b1) begin
                    bad++; $display("FAIL round_valid %0d: got %b want 1", j - 2, b_out_valid);
                end
                total++;
                if (b_out_data !== vexp[j-2]) begin
                    bad++; $display("FAIL round_data %0d: got %0d want %0d", j - 2, $signed(b_out_data), $signed(vexp[j-2]));
                end
            end
        end
        b_in_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_saturation();
        logic [29:0] vin [2];
        logic [15:0] vexp [2];
        logic        sat_exp;
        vin[0] = 30'sd536870911;
        vin[1] = -30'sd536870912;
`ifdef FIR_OUT_DECIM_SAT_EN
        vexp[0] = 16'h7FFF; vexp[1] = 16'h8000; sat_exp = 1'b1;
`else
        vexp[0] = 16'h0000; vexp[1] = 16'h0000; sat_exp = 1'b0;
`endif
        do_reset();
        b_out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            b_in_valid = (j < 2);
            b_din      = (j < 2) ? vin[j] : 30'd0;
            step();
            if (j >= 2) begin
                total++;
                if (b_out_data !== vexp[j-2]) begin
                    bad++; $display("FAIL sat_data %0d: got %0d want %0d", j - 2, $signed(b_out_data), $signed(vexp[j-2]));
                end
            end
        end
        b_in_valid = 1'b0;
        step();
        total++;
        if (b_sat !== sat_exp) begin bad++; $display("FAIL sat_flag: got %b want %b", b_sat, sat_exp); end
    endtask

    task automatic test_backpressure();
        do_reset();
        b_out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            b_in_valid = 1'b1;
            b_din      = 30'((j + 1) * 4096);
            step();
        end
        b_in_valid = 1'b0;
        step(); step(); step();
        total++; if (b_fill !== 3'd4)      begin bad++; $display("FAIL bp_fill: got %0d want 4", b_fill); end
        total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", b_out_valid); end
        total++; if (b_out_data !== 16'd1) begin bad++; $display("FAIL bp_head: got %0d want 1", b_out_data); end
        total++; if (b_ovf !== 1'b1)       begin bad++; $display("FAIL bp_ovf: got %b want 1", b_ovf); end
        b_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (b_out_data !== 16'(k)) begin bad++; $display("FAIL bp_read %0d: got %0d want %0d", k, b_out_data, k); end
            step();
        end
        total++; if (b_fill !== 3'd0)      begin bad++; $display("FAIL bp_empty_fill: got %0d want 0", b_fill); end
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty_valid: got %b want 0", b_out_valid); end
        total++; if (b_ovf !== 1'b1)       begin bad++; $display("FAIL bp_ovf_sticky: got %b want 1", b_ovf); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        b_out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            b_in_valid = 1'b1;
            b_din      = 30'((j + 1) * 4096);
            step();
        end
        b_in_valid = 1'b0;
        step(); step(); step();
        total++; if (b_fill !== 3'd4) begin bad++; $display("FAIL fp_prefill: got %0d want 4", b_fill); end
        // sample 5 reaches the FIFO two edges later, exactly when the pop is granted
        b_in_valid = 1'b1;
        b_din      = 30'd20480;
        step();
        b_in_valid = 1'b0;
        step();
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        total++; if (b_fill !== 3'd4)      begin bad++; $display("FAIL fp_fill: got %0d want 4", b_fill); end
        total++; if (b_ovf !== 1'b0)       begin bad++; $display("FAIL fp_ovf: got %b want 0", b_ovf); end
        total++; if (b_out_data !== 16'd2) begin bad++; $display("FAIL fp_head: got %0d want 2", b_out_data); end
        b_out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            total++;
            if (b_out_data !== 16'(k)) begin bad++; $display("FAIL fp_read %0d: got %0d want %0d", k, b_out_data, k); end
            step();
        end
        total++; if (b_fill !== 3'd0) begin bad++; $display("FAIL fp_empty: got %0d want 0", b_fill); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        do_reset();
        // DUT a streams throughout so it is past warm-up when the reset hits
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_din       = 30'd4096;
        b_out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            b_in_valid = 1'b1;
            b_din      = 30'((j + 1) * 4096);
            step();
        end
        b_in_valid = 1'b0;
        for (int j = 0; j < 12; j++) step();
        total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL rm_pre_ovf: got %b want 1", b_ovf); end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        total++; if (b_fill !== 3'd3) begin bad++; $display("FAIL rm_pre_fill: got %0d want 3", b_fill); end
        // put one more sample in flight, then reset while a push/pop would also happen
        b_in_valid = 1'b1;
        b_din      = 30'd28672;
        step();
        b_out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        total++; if (b_fill !== 3'd0)      begin bad++; $display("FAIL rm_fill: got %0d want 0", b_fill); end
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", b_out_valid); end
        total++; if (b_ovf !== 1'b0)       begin bad++; $display("FAIL rm_ovf: got %b want 0", b_ovf); end
        total++; if (b_sat !== 1'b0)       begin bad++; $display("FAIL rm_sat: got %b want 0", b_sat); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rm_a_valid: got %b want 0", a_out_valid); end
        // a restarts warm-up: first output 16 edges after the reset edge; b stays empty
        for (int e = 1; e <= 16; e++) begin
            step();
            exp_v = (e == 16);
            total++;
            if (a_out_valid !== exp_v) begin
                bad++; $display("FAIL rm_warm edge %0d: got %b want %b", e, a_out_valid, exp_v);
            end
            total++;
            if (b_out_valid !== 1'b0) begin
                bad++; $display("FAIL rm_b_idle edge %0d: got %b want 0", e, b_out_valid);
            end
        end
        a_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_din = 30'd0; b_din = 30'd0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        test_reset();
        test_warmup();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
